// File: rtl/alu_seq.sv
// Multi-precision operation sequencer: issues one NBYTES-wide operation to an
// external combinational 8-bit ALU one byte per cycle, LSB first, chaining carry.
module alu_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_oper,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic                  req_c_in,
    output logic [2:0]            alu_oper,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_c_in,
    input  logic [7:0]            alu_sum,
    input  logic                  alu_c_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_result,
    output logic                  rsp_c_out,
    output logic                  busy
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [2:0]      oper_q, oper_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            c_out_q, c_out_d;
    logic            rsp_valid_q, rsp_valid_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        oper_d      = oper_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        c_out_d     = c_out_q;
        rsp_valid_d = rsp_valid_q;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_c_in    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    oper_d  = req_oper;
                    a_d     = req_a;
                    b_d     = req_b;
                    carry_d = req_c_in;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                alu_a = a_q[8*idx_q +: 8];
                alu_b = b_q[8*idx_q +: 8];
                case (oper_q)
                    3'd0, 3'd1: alu_c_in = carry_q;
                    // The ALU inverts c_in for oper 2, so a borrow chain feeds back ~c_out.
                    3'd2:       alu_c_in = (idx_q == '0) ? carry_q : ~carry_q;
                    default:    alu_c_in = 1'b0;
                endcase

                result_d[8*idx_q +: 8] = alu_sum;
                carry_d                = alu_c_out;
                if (idx_q == IW'(NBYTES - 1)) begin
                    c_out_d     = alu_c_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; async active-low reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            oper_q      <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            oper_q      <= oper_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            c_out_q     <= c_out_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign alu_oper   = oper_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_c_out  = c_out_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes word-level expected results,
// a monitor pops and compares whenever a response is presented.
module tb_alu_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_oper;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_c_in;
    logic [2:0]    alu_oper;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_c_in;
    logic [7:0]    alu_sum;
    logic          alu_c_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_c_out;
    logic          busy;

    alu_seq #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_oper   (req_oper),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c_in   (req_c_in),
        .alu_oper   (alu_oper),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c_in   (alu_c_in),
        .alu_sum    (alu_sum),
        .alu_c_out  (alu_c_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_c_out  (rsp_c_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU: 0 add, 1 a+~b+c, 2 b+~a+~c, 3 and, 4 or, 5 not a, 6 xor, 7 pass b
    always_comb begin
        logic [8:0] t;
        t = 9'h000;
        case (alu_oper)
            3'd0:    t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_c_in};
            3'd1:    t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_c_in};
            3'd2:    t = {1'b0, alu_b} + {1'b0, ~alu_a} + {8'h00, ~alu_c_in};
            3'd3:    t = {1'b0, alu_a & alu_b};
            3'd4:    t = {1'b0, alu_a | alu_b};
            3'd5:    t = {1'b0, ~alu_a};
            3'd6:    t = {1'b0, alu_a ^ alu_b};
            default: t = {1'b0, alu_b};
        endcase
        alu_sum   = t[7:0];
        alu_c_out = t[8];
    end

    typedef struct {
        logic [W-1:0]  res;
        logic          c;
        logic [NB-1:0] cin;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    logic cin_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rr_rand = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Word-level reference: plain wide arithmetic, plus the carry seen entering each byte.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, output logic [W-1:0] r, output logic c,
                                  output logic [NB-1:0] cv);
        logic [W:0] s, m, al, bl, s2;
        c  = 1'b0;
        cv = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(ci); r = s[W-1:0]; c = s[W]; end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + (W+1)'(ci); r = s[W-1:0]; c = s[W]; end
            3'd2: begin r = b - a - W'(ci); c = ({1'b0, b} >= ({1'b0, a} + (W+1)'(ci))); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = ~a;
            3'd6: r = a ^ b;
            default: r = b;
        endcase
        for (int i = 0; i < NB; i++) begin
            m  = ((W+1)'(1) << (8 * i)) - 1;
            al = {1'b0, a} & m;
            bl = ((op == 3'd1) ? {1'b0, ~b} : {1'b0, b}) & m;
            s2 = al + bl + (W+1)'(ci);
            if (op <= 3'd1)      cv[i] = s2[8*i];
            else if (op == 3'd2) cv[i] = (i == 0) ? ci : (bl < al + (W+1)'(ci));
        end
    endfunction

    // Monitor: collects per-byte carry-in while running and scores each response.
    exp_t         mon_e;
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_res   = '0;
    logic [NB-1:0] got_cin;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (busy && !rsp_valid) cin_q.push_back(alu_c_in);
            if (rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, required 0");
                end else begin
                    mon_e   = exp_q[0];
                    got_cin = '0;
                    for (int i = 0; i < cin_q.size() && i < NB; i++) got_cin[i] = cin_q[i];
                    check("rsp_result", rsp_result, mon_e.res);
                    check("rsp_c_out", rsp_c_out, mon_e.c);
                    check("latency", cyc - mon_e.acc, NB);
                    check("run_cycles", cin_q.size(), NB);
                    check("alu_c_in_seq", got_cin, mon_e.cin);
                end
            end
            if (rsp_valid && prev_valid) begin
                check("rsp_stable", rsp_result, prev_res);
                check("req_ready_done", req_ready, 1'b0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                cin_q.delete();
            end
            prev_valid = rsp_valid;
            prev_res   = rsp_result;
        end
    end

    always @(posedge clk) begin
        if (rr_rand) begin
            #1;
            rsp_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit use_k, input logic [W-1:0] kres, input logic kc);
        exp_t e;
        int   g;
        model(op, a, b, ci, e.res, e.c, e.cin);
        if (use_k) begin
            e.res = kres;
            e.c   = kc;
        end
        req_oper  = op;
        req_a     = a;
        req_b     = b;
        req_c_in  = ci;
        req_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", g);
            req_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        // A second request with junk operands while busy must be ignored.
        req_oper = 3'($urandom);
        req_a    = $urandom;
        req_b    = $urandom;
        req_c_in = 1'($urandom);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick_w();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_oper  = 3'd0;
        req_a     = '0;
        req_b     = '0;
        req_c_in  = 1'b0;
        rsp_ready = 1'b1;
        #2;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_c_out", rsp_c_out, 1'b0);
        check("rst_alu_oper", alu_oper, 3'd0);
        check("rst_busy", busy, 1'b0);
        #10;
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("idle_alu_a", alu_a, 8'h00);
        @(posedge clk);
        #1;

        send(3'd0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h0100_0000, 1'b0);
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h0000_0000, 1'b1);
        send(3'd1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1, 32'hFFFF_FFFF, 1'b0);
        send(3'd2, 32'h0000_0001, 32'h0000_0100, 1'b0, 1, 32'h0000_00FF, 1'b1);
        wait_drain();

        // Back-pressure: response must hold while rsp_ready stays low.
        rsp_ready = 1'b0;
        send(3'd6, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 1, 32'h5A5A_A5A5, 1'b0);
        for (int g = 0; g < 50 && !rsp_valid; g++) @(negedge clk);
        check("hold_seen_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", rsp_valid, 1'b0);
        check("post_hs_req_ready", req_ready, 1'b1);

        // Reset during RUN byte 2 discards the operation.
        send(3'd0, 32'h1234_5678, 32'h8765_4321, 1'b1, 0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 1'b0);
        check("mid_rst_result", rsp_result, 0);
        check("mid_rst_c_out", rsp_c_out, 1'b0);
        check("mid_rst_alu_oper", alu_oper, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        exp_q.delete();
        cin_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(3'd0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h0100_0000, 1'b0);
        wait_drain();

        rr_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            send(3'($urandom_range(0, 7)), pick_w(), pick_w(), 1'($urandom), 0, '0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rr_rand = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
